// File: rtl/crt_pkg.sv
// Shared definitions for the CRT reconstruction engine: FSM state encoding and default width.
package crt_pkg;

    localparam int CRT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        SUB,
        MUL,
        RECON,
        DONE
    } crt_state_e;

endpackage

// File: rtl/crt_reconstruct_mod_mul_serial.sv
// Bit-serial MSB-first interleaved modular multiplier: p = (a * b) mod m in WIDTH cycles.
// The load cycle already consumes b[WIDTH-1]; valid pulses once with p.
module mod_mul_serial
    import crt_pkg::*;
#(
    parameter int WIDTH = CRT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] p
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] b_sh;
    logic [CNT_W-1:0] cnt;
    logic             running;

    // One interleaved step; operands stay below m, so WIDTH+1 bits never overflow.
    function automatic logic [WIDTH-1:0] mod_step(
        input logic [WIDTH-1:0] acc_in,
        input logic [WIDTH-1:0] d,
        input logic             bit_i,
        input logic [WIDTH-1:0] mod
    );
        logic [WIDTH:0] t;
        t = {acc_in, 1'b0};
        if (t >= {1'b0, mod}) t = t - {1'b0, mod};
        if (bit_i) begin
            t = t + {1'b0, d};
            if (t >= {1'b0, mod}) t = t - {1'b0, mod};
        end
        return t[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            a_q     <= '0;
            m_q     <= '0;
            b_sh    <= '0;
            cnt     <= '0;
            running <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (load) begin
                acc     <= mod_step('0, a, b[WIDTH-1], m);
                a_q     <= a;
                m_q     <= m;
                b_sh    <= b << 1;
                cnt     <= CNT_W'(WIDTH - 1);
                running <= (WIDTH > 1);
                valid   <= (WIDTH == 1);
            end else if (running) begin
                acc  <= mod_step(acc, a_q, b_sh[WIDTH-1], m_q);
                b_sh <= b_sh << 1;
                cnt  <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    running <= 1'b0;
                    valid   <= 1'b1;
                end
            end
        end
    end

    assign busy = running;
    assign p    = acc;

endmodule

// File: rtl/crt_reconstruct.sv
// Two-modulus CRT reconstruction (Garner): x = r1 + m1 * (((r2 - r1) * m1_inv) mod m2).
// Define CRT_INPUT_CHECK_EN to range-check operands and flag violations on err.
module crt_reconstruct
    import crt_pkg::*;
#(
    parameter int WIDTH = CRT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   r1,
    input  logic [WIDTH-1:0]   r2,
    input  logic [WIDTH-1:0]   m1,
    input  logic [WIDTH-1:0]   m2,
    input  logic [WIDTH-1:0]   m1_inv,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] x,
    output logic               err
);

    crt_state_e state, state_nxt;

    logic [WIDTH-1:0]   r1_q, r2_q, m1_q, m2_q, inv_q;
    logic [WIDTH-1:0]   d;
    logic [2*WIDTH-1:0] recon;
    logic [2*WIDTH-1:0] xr_q;
    logic               bad_q;
    logic               viol;
    logic               accept;
    logic               mul_load;
    logic               mul_busy;
    logic               mul_valid;
    logic [WIDTH-1:0]   mul_p;

    // r1 < m2 keeps m2 - (r1 - r2) positive, so the wrap branch needs no extra bit.
    always_comb begin
        d = '0;
        if (r2_q >= r1_q) d = r2_q - r1_q;
        else              d = m2_q - (r1_q - r2_q);
    end

`ifdef CRT_INPUT_CHECK_EN
    assign viol = (m2_q == '0) || (m1_q >= m2_q) || (r1_q >= m1_q) || (r2_q >= m2_q);
`else
    assign viol = 1'b0;
`endif

    assign recon = {{WIDTH{1'b0}}, r1_q} + ({{WIDTH{1'b0}}, m1_q} * {{WIDTH{1'b0}}, mul_p});

    mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .reset (reset),
        .load  (mul_load),
        .a     (d),
        .b     (inv_q),
        .m     (m2_q),
        .busy  (mul_busy),
        .valid (mul_valid),
        .p     (mul_p)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SUB;
            SUB:     state_nxt = viol ? DONE : MUL;
            MUL:     if (mul_valid && !mul_busy) state_nxt = RECON;
            RECON:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept   = (state == IDLE) && start;
        mul_load = (state == SUB) && !viol;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r1_q  <= '0;
            r2_q  <= '0;
            m1_q  <= '0;
            m2_q  <= '0;
            inv_q <= '0;
            bad_q <= 1'b0;
            xr_q  <= '0;
            x     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                r1_q  <= r1;
                r2_q  <= r2;
                m1_q  <= m1;
                m2_q  <= m2;
                inv_q <= m1_inv;
                busy  <= 1'b1;
            end
            if (state == SUB)   bad_q <= viol;
            if (state == RECON) xr_q  <= recon;
            if (state == DONE) begin
                x    <= bad_q ? '0 : xr_q;
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

`ifdef CRT_INPUT_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             err <= 1'b0;
        else if (accept)        err <= 1'b0;
        else if (state == DONE) err <= bad_q;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_crt_reconstruct.sv
// Directed bench for crt_reconstruct at WIDTH=8 (m1=5, m2=7, m1_inv=3); honours CRT_INPUT_CHECK_EN.
module tb_crt_reconstruct;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   r1, r2, m1, m2, m1_inv;
    logic           busy, done, err;
    logic [2*W-1:0] x;

    int n_tests = 0;
    int n_fail  = 0;

    crt_reconstruct #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .r1     (r1),
        .r2     (r2),
        .m1     (m1),
        .m2     (m2),
        .m1_inv (m1_inv),
        .busy   (busy),
        .done   (done),
        .x      (x),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request; lat counts edges from the accepting edge until done is seen.
    task automatic run_op(input logic [W-1:0] a1, input logic [W-1:0] a2,
                          input logic [W-1:0] mm1, input logic [W-1:0] mm2,
                          input logic [W-1:0] inv, input bit alter, output int lat);
        @(negedge clk);
        r1 = a1; r2 = a2; m1 = mm1; m2 = mm2; m1_inv = inv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (alter) begin
            r1 = 8'd4;
            r2 = 8'd6;
        end
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int nd;
        int bl;
        int dk [0:3];

        reset = 1'b0; start = 1'b0;
        r1 = '0; r2 = '0; m1 = '0; m2 = '0; m1_inv = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_x",    x,    0);
        chk("rst_err",  err,  0);
        @(negedge clk);
        reset = 1'b1;

        // Basic reconstruction and latency
        @(negedge clk);
        r1 = 8'd3; r2 = 8'd2; m1 = 8'd5; m2 = 8'd7; m1_inv = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("lat_3_2", lat, 11);
        chk("x_3_2",   x,   23);
        chk("err_3_2", err, 0);
        chk("busy_at_done", busy, 0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        chk("x_hold", x, 23);

        run_op(8'd4, 8'd6, 8'd5, 8'd7, 8'd3, 1'b0, lat);
        chk("x_max", x, 34);
        chk("lat_max", lat, 11);
        run_op(8'd0, 8'd0, 8'd5, 8'd7, 8'd3, 1'b0, lat);
        chk("x_zero", x, 0);

        // Continuous start for 30 edges
        @(negedge clk);
        r1 = 8'd1; r2 = 8'd1; m1 = 8'd5; m2 = 8'd7; m1_inv = 8'd3;
        start = 1'b1;
        nd = 0; bl = 0;
        for (int k = 0; k < 46; k++) begin
            @(posedge clk);
            #1;
            if (k == 29) start = 1'b0;
            if (done) begin
                if (nd < 4) dk[nd] = k;
                nd++;
                chk("cont_x", x, 1);
            end
            if (nd == 1 && !busy) bl++;
        end
        chk("cont_ndone", nd, 3);
        chk("cont_first", dk[0], 11);
        chk("cont_gap1", dk[1] - dk[0], 12);
        chk("cont_gap2", dk[2] - dk[1], 12);
        chk("cont_busy_low", bl, 1);

        run_op(8'd3, 8'd2, 8'd5, 8'd7, 8'd3, 1'b1, lat);
        chk("x_latched", x, 23);

        // Abort mid-run by reset
        @(negedge clk);
        r1 = 8'd4; r2 = 8'd6; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_x",    x,    0);
        @(negedge clk);
        reset = 1'b1;
        run_op(8'd3, 8'd2, 8'd5, 8'd7, 8'd3, 1'b0, lat);
        chk("post_abort_x", x, 23);
        chk("post_abort_lat", lat, 11);

        // Out-of-range moduli
        run_op(8'd1, 8'd1, 8'd7, 8'd5, 8'd3, 1'b0, lat);
`ifdef CRT_INPUT_CHECK_EN
        chk("bad_lat", lat, 2);
        chk("bad_err", err, 1);
        chk("bad_x",   x,   0);
`else
        chk("bad_lat", lat, 11);
        chk("bad_err", err, 0);
`endif
        run_op(8'd3, 8'd2, 8'd5, 8'd7, 8'd3, 1'b0, lat);
        chk("recover_err", err, 0);
        chk("recover_x",   x,   23);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/crt_reconstruct.md
# crt_reconstruct

Two-modulus Chinese Remainder Theorem reconstruction engine, using Garner's form x = r1 + m1·(((r2 − r1) · m1⁻¹) mod m2). It rebuilds a 2·WIDTH-bit integer from its residues modulo m1 and m2. It sits downstream of the CRT inverse generator, which supplies m1⁻¹ mod m2 as an operand. Operation is multi-cycle and iterative: a start/busy/done handshake and a bit-serial modular multiplier, so no wide `%` operator is needed.

## Interface
- WIDTH, 32, bit width of moduli, residues and inverse
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- r1  input  WIDTH  residue mod m1 (must satisfy r1 < m1)
- r2  input  WIDTH  residue mod m2 (must satisfy r2 < m2)
- m1  input  WIDTH  first modulus (must satisfy m1 < m2)
- m2  input  WIDTH  second modulus, nonzero
- m1_inv  input  WIDTH  m1⁻¹ mod m2
- busy  output  1  high from the cycle after start acceptance until done
- done  output  1  one-cycle pulse; x and err are valid
- x  output  2·WIDTH  reconstructed value, 0 ≤ x < m1·m2
- err  output  1  operand range violation (see Configuration)

## Operation
- Reset (async, low): state IDLE; busy = 0, done = 0, x = 0, err = 0; all internal registers cleared.
- IDLE: on start = 1, latch r1, r2, m1, m2, m1_inv and go to SUB. Inputs may change freely after acceptance.
- SUB: d = (r2 ≥ r1) ? r2 − r1 : r2 + m2 − r1. Compute in WIDTH+1 bits, so d < m2. Clear acc and set bit index i = WIDTH−1. Go to MUL.
- MUL: WIDTH iterations, MSB-first interleaved modular multiply, one bit per cycle:
  - acc = 2·acc; if acc ≥ m2 then acc −= m2.
  - If m1_inv[i] = 1: acc += d; if acc ≥ m2 then acc −= m2.
  - All intermediates are WIDTH+1 bits.
  - After i = 0, h = acc. Go to RECON.
- RECON: x_next = r1 + m1·h, computed in 2·WIDTH bits; it cannot overflow. Go to DONE.
- DONE: register x, assert done for one cycle, deassert busy, return to IDLE.
- x holds its value until the next DONE or reset.
- start while busy is ignored; there is no queueing.
- start asserted in the DONE cycle is ignored; it is accepted only once the FSM is back in IDLE.
- Reset asserted mid-operation aborts immediately. No done pulse is produced.

## Timing
- Start accepted at edge T. busy = 1 from T+1. SUB occupies T+1. MUL occupies T+2 … T+WIDTH+1. RECON occupies T+WIDTH+2.
- done = 1 and x valid in the cycle after edge T+WIDTH+3.
- Latency is WIDTH+3 cycles.
- Throughput is one result per WIDTH+4 cycles, because a new start is accepted in IDLE only.
- Error path (macro enabled): start at T → done with err = 1 after edge T+2.

## Configuration
- CRT_INPUT_CHECK_EN defined:
  - In the SUB cycle, check m2 = 0, m1 ≥ m2, r1 ≥ m1 and r2 ≥ m2.
  - On any violation: go straight to DONE, x = 0, err = 1 with done.
  - err clears on the next accepted start.
- CRT_INPUT_CHECK_EN undefined:
  - No checks; err is tied to 0.
  - Out-of-range operands give an unspecified x, but latency is unchanged.

## Structure
- Package crt_pkg holds:
  - the state enum (IDLE, SUB, MUL, RECON, DONE);
  - the default width constant CRT_WIDTH = 32.
- Sub-module mod_mul_serial holds the MUL loop:
  - ports: clk, reset, load, a, b, m, busy, valid, p;
  - WIDTH-cycle interleaved multiply.
  - It is reusable by the inverse generator.
- The top level keeps the SUB and RECON datapath and the control FSM.

## Test plan
All scenarios use WIDTH = 8, m1 = 5, m2 = 7, m1_inv = 3 unless stated.
- r1 = 3, r2 = 2 → d = 6, h = 4, x = 23, done exactly 11 cycles after the start edge, err = 0.
- r1 = 4, r2 = 6 → x = 34, the maximum m1·m2 − 1; r1 = 0, r2 = 0 → x = 0.
- start held high continuously for 30 cycles with r1 = 1, r2 = 1 → x = 1 on every done; done pulses are 12 cycles apart; busy drops for exactly 1 cycle between runs.
- Operands changed to r1 = 4, r2 = 6 one cycle after the start edge of a r1 = 3, r2 = 2 request → x = 23, showing operands are latched.
- reset pulled low at cycle 5 of a run → busy = 0, done = 0, x = 0 immediately; the next start with r1 = 3, r2 = 2 → x = 23.
- With CRT_INPUT_CHECK_EN: m1 = 7, m2 = 5 → done after 2 cycles with err = 1, x = 0. Without the macro → err stays 0.
